// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor built from two half-subtractor stages,
// the subtract counterpart of the two-half-cell full adder.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic BO,
  output logic D
);

  logic d1;
  logic bo1;
  logic bo2;

  // First half cell: A - B
  assign d1  = A ^ B;
  assign bo1 = ~A & B;

  // Second half cell: (A - B) - BI
  assign D   = d1 ^ BI;
  assign bo2 = ~d1 & BI;

  assign BO  = bo1 | bo2;

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: D = A - B - BIN over WIDTH cycles using one cell.
// Optional flags Z/V are enabled with macro SERIAL_SUB_FLAGS_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             Z,
  output logic             V
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             borrow;
  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] r_next;

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb;
  logic b_msb;
`endif

  full_subtractor u_cell (
    .A  (a_sr[0]),
    .B  (b_sr[0]),
    .BI (borrow),
    .BO (cell_bo),
    .D  (cell_d)
  );

  // Result bits arrive LSB first, so each new bit enters at the MSB end.
  assign r_next = {cell_d, r_sr[WIDTH-1:1]};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      D      <= '0;
      BOUT   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      Z      <= 1'b0;
      V      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= BIN;
            cnt    <= '0;
            BUSY   <= 1'b1;
            state  <= ST_RUN;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
`endif
          end
        end

        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= r_next;
          borrow <= cell_bo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            D     <= r_next;
            BOUT  <= cell_bo;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= ST_DONE;
`ifdef SERIAL_SUB_FLAGS_EN
            Z     <= (r_next == '0);
            V     <= (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
`endif
          end
        end

        ST_DONE: begin
          DONE  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing D = A - B - BIN over WIDTH clock cycles.
- Uses one combinational full-subtractor cell plus a borrow flip-flop, trading area for latency.
- Sits beside the ripple adder primitives in the arithmetic library.
- Intended for the datapath's low-area subtract and compare operations.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
CLK  input  1  single system clock; all state updates on rising edge.
RST_N  input  1  reset, synchronous, active-low.
START  input  1  request; sampled only in IDLE.
A  input  WIDTH  minuend; captured on accepted START.
B  input  WIDTH  subtrahend; captured on accepted START.
BIN  input  1  borrow-in; captured on accepted START.
BUSY  output  1  high while bits are being processed (RUN).
DONE  output  1  one-cycle completion pulse.
D  output  WIDTH  difference; registered, held until next completion.
BOUT  output  1  final borrow-out; registered, held with D.

Behaviour:
- Reset: RST_N low at a rising edge clears state to IDLE, the bit counter, the operand shift registers and the borrow FF.
  - Also forces BUSY=0, DONE=0, D=0, BOUT=0.
  - Reset during RUN or DONE aborts the operation; no DONE pulse follows.
- State machine, with the state register as the only control state:
  - IDLE: BUSY=0. If START=1 at edge t0, latch A, B and BIN (into the borrow FF), clear the counter, and go to RUN.
  - RUN: BUSY=1. At each of edges t0+1 .. t0+WIDTH, the cell consumes bit[0] of both shift registers and the borrow FF.
    - Both operand registers shift right.
    - The difference bit shifts into the MSB of the internal result shift register.
    - The borrow FF takes the cell borrow-out.
    - The counter increments.
    - At edge t0+WIDTH (counter == WIDTH-1 before the edge), D is loaded from the completed result and BOUT from the final borrow, and the state goes to DONE.
  - DONE: DONE=1 and BUSY=0 for exactly one cycle, then unconditionally return to IDLE.
- Latency: DONE is high in the cycle beginning WIDTH edges after the edge that accepted START.
  - Throughput is one operation per WIDTH+2 cycles (back-to-back START).
- START while in RUN or DONE is ignored; the operands in flight are unaffected and no queueing occurs.
  - START held high continuously is re-accepted on the first IDLE cycle.
- D and BOUT change only at the completion edge; they stay stable during a subsequent RUN.
- Cell equations (per bit):
  - d = a ^ b ^ bi
  - bo = (~a & b) | (~(a ^ b) & bi)
- Arithmetic: unsigned modulo 2^WIDTH. BOUT=1 iff A < B + BIN, unsigned.
- Counter width: $clog2(WIDTH), minimum 1 bit. Its wrap is never reached because RUN exits at WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_FLAGS_EN.
- Defined: adds outputs Z (1 bit) and V (1 bit), both registered and loaded at the completion edge alongside D.
  - Z = (D == 0).
  - V = signed two's-complement overflow = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), using the captured operand MSBs.
  - Both reset to 0.
- Not defined: the Z and V ports, the flag registers and the captured MSBs are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and a 2-bit state typedef;
  - DEFAULT_WIDTH=8.
- One sub-module, full_subtractor (inputs A, B, BI; outputs BO, D), instantiated once as the serial cell.
  - It is purely combinational, and structurally mirrors the existing full adder built from two half cells.

Test Plan:
1. WIDTH=8, A=8'h5A, B=8'h21, BIN=0, START pulse -> BUSY high 8 cycles, DONE pulse on 8th edge after START; D=8'h39, BOUT=0.
2. A=8'h10, B=8'h20, BIN=0 -> D=8'hF0, BOUT=1.
3. A=8'h00, B=8'h00, BIN=1 -> D=8'hFF, BOUT=1. Then A=8'hFF, B=8'hFF, BIN=0 back-to-back with START held high -> D=8'h00, BOUT=0, second DONE exactly 10 cycles after first.
4. A=8'h40, B=8'h01 started; mid-RUN at cycle 3 drive START=1 with A=8'hAA, B=8'h55 -> ignored; DONE once, D=8'h3F; D stays 8'h3F until a new accepted START completes.
5. RST_N=0 for one edge at RUN cycle 4 -> next cycle BUSY=0, DONE=0, D=0, BOUT=0; no DONE afterward. A fresh START with A=8'h07, B=8'h03 -> D=8'h04.
6. With SERIAL_SUB_FLAGS_EN: A=8'h80, B=8'h01 -> D=8'h7F, V=1, Z=0, BOUT=0. Then A=B=8'h33 -> D=0, Z=1, V=0. Without the macro, the bench compiles with the Z and V ports absent.
